// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - multi-channel down-counting timer bank with register interface (optional TIMER_BANK_OUT_EN enables toggle outputs)
module timer_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [5:0]          AD,
    input  logic [7:0]          DI,
    output logic [7:0]          DO,
    input  logic                rw,
    input  logic                cs,
    output logic                irq,
    output logic [CHANNELS-1:0] tout
);

`ifdef TIMER_BANK_OUT_EN
    localparam logic OUT_EN = 1'b1;
`else
    localparam logic OUT_EN = 1'b0;
`endif

    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] ien_q, ien_d;
    logic [CHANNELS-1:0] run_q, run_d;
    logic [CHANNELS-1:0] oneshot_q, oneshot_d;
    logic [CHANNELS-1:0] outen_q, outen_d;
    logic [CHANNELS-1:0] tout_q, tout_d;
    logic [CHANNELS-1:0] pend_set;
    logic [WIDTH-1:0]    reload_q [CHANNELS];
    logic [WIDTH-1:0]    reload_d [CHANNELS];
    logic [WIDTH-1:0]    count_q  [CHANNELS];
    logic [WIDTH-1:0]    count_d  [CHANNELS];
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [7:0]          do_q, do_d;
    logic [7:0]          rdata;
    logic [23:0]         wr_pad;
    logic [23:0]         rd_pad;
    logic                wr_en;
    logic                rd_en;
    logic [2:0]          ch_sel;
    logic [2:0]          off;

    assign wr_en  = cs & ~rw;
    assign rd_en  = cs & rw;
    assign ch_sel = AD[5:3];
    assign off    = AD[2:0];

    assign DO   = do_q;
    assign irq  = |(pend_q & ien_q);
    assign tout = tout_q;

    // Per-channel counting, expiry handling and register writes
    always_comb begin
        pend_set  = '0;
        ien_d     = ien_q;
        run_d     = run_q;
        oneshot_d = oneshot_q;
        outen_d   = outen_q;
        tout_d    = tout_q;
        reload_d  = reload_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        wr_pad    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (run_q[n]) begin
                if (count_q[n] != '0) begin
                    count_d[n] = count_q[n] - WIDTH'(1);
                end else begin
                    pend_set[n] = 1'b1;
                    if (outen_q[n]) tout_d[n] = ~tout_q[n];
                    if (oneshot_q[n]) run_d[n] = 1'b0;
                    else              count_d[n] = reload_q[n];
                end
            end
            if (wr_en && ch_sel == 3'(n + 1)) begin
                case (off)
                    3'd0: begin
                        oneshot_d[n] = DI[1];
                        outen_d[n]   = DI[2] & OUT_EN;
                        // Stopping freezes the count; starting loads RELOAD
                        // and suppresses this cycle's decrement.
                        if (!DI[0]) begin
                            run_d[n]   = 1'b0;
                            count_d[n] = count_q[n];
                        end else if (!run_q[n]) begin
                            run_d[n]   = 1'b1;
                            count_d[n] = reload_q[n];
                        end
                    end
                    3'd1, 3'd2, 3'd3: begin
                        // Bytes above WIDTH fall off in the truncation.
                        wr_pad = 24'(reload_q[n]);
                        case (off)
                            3'd1:    wr_pad[7:0]   = DI;
                            3'd2:    wr_pad[15:8]  = DI;
                            default: wr_pad[23:16] = DI;
                        endcase
                        reload_d[n] = wr_pad[WIDTH-1:0];
                    end
                    default: ;
                endcase
            end
            if (rd_en && ch_sel == 3'(n + 1) && off == 3'd5) begin
                shadow_d[n] = count_q[n];
            end
        end
        if (wr_en && AD == 6'd1) ien_d = DI[CHANNELS-1:0];
    end

    // Pending status: write-1-to-clear, with a same-cycle expiry winning
    always_comb begin
        pend_d = pend_q;
        if (wr_en && AD == 6'd0) pend_d = pend_q & ~DI[CHANNELS-1:0];
        pend_d = pend_d | pend_set;
    end

    // Read data mux; unmapped locations return 0
    always_comb begin
        rdata  = '0;
        rd_pad = '0;
        if (AD == 6'd0) rdata = 8'(pend_q);
        if (AD == 6'd1) rdata = 8'(ien_q);
        for (int n = 0; n < CHANNELS; n++) begin
            if (ch_sel == 3'(n + 1)) begin
                case (off)
                    3'd0: rdata = {5'd0, outen_q[n], oneshot_q[n], run_q[n]};
                    3'd1, 3'd2, 3'd3: begin
                        rd_pad = 24'(reload_q[n]);
                        case (off)
                            3'd1:    rdata = rd_pad[7:0];
                            3'd2:    rdata = rd_pad[15:8];
                            default: rdata = rd_pad[23:16];
                        endcase
                    end
                    3'd5: rdata = count_q[n][7:0];
                    3'd6: begin
                        rd_pad = 24'(shadow_q[n]);
                        rdata  = rd_pad[15:8];
                    end
                    3'd7: begin
                        rd_pad = 24'(shadow_q[n]);
                        rdata  = rd_pad[23:16];
                    end
                    default: rdata = '0;
                endcase
            end
        end
        do_d = rd_en ? rdata : do_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend_q    <= '0;
            ien_q     <= '0;
            run_q     <= '0;
            oneshot_q <= '0;
            outen_q   <= '0;
            tout_q    <= '0;
            do_q      <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                reload_q[n] <= '0;
                count_q[n]  <= '0;
                shadow_q[n] <= '0;
            end
        end else begin
            pend_q    <= pend_d;
            ien_q     <= ien_d;
            run_q     <= run_d;
            oneshot_q <= oneshot_d;
            outen_q   <= outen_d;
            tout_q    <= tout_d;
            do_q      <= do_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
        end
    end

endmodule
